dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl_if.sv | 30 +++
 rtl/dcache_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// Bus interface for dcache_ctrl: CPU (MEM stage) side and backing-memory side.
// slave modport is the cache's view; master modport is the surrounding system's view.
interface dcache_ctrl_if #(
    parameter int unsigned LINE_BITS = 256
);
    // CPU side
    logic                 cpu_req_i;
    logic                 cpu_we_i;
    logic [31:0]          cpu_addr_i;
    logic [31:0]          cpu_data_i;
    logic [31:0]          cpu_data_o;
    logic                 cpu_stall_o;
    // Backing-memory side
    logic                 mem_enable_o;
    logic                 mem_write_o;
    logic [31:0]          mem_addr_o;
    logic [LINE_BITS-1:0] mem_data_o;
    logic [LINE_BITS-1:0] mem_data_i;
    logic                 mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 32 lines x 256 bits; tag = addr[31:10], index = addr[9:5], word = addr[4:2].
// Hits complete in the IDLE cycle with no stall; misses stall the pipeline while the
// victim is written back (if dirty) and the line is refilled.
// Optional: define DCACHE_STATS_EN to add hit_cnt_o / miss_cnt_o counters.
module dcache_ctrl #(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned LINE_BITS = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dcache_ctrl_if.slave      bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int unsigned IdxW = 5;
    localparam int unsigned TagW = 22;

    typedef enum logic [1:0] {StIdle, StWriteback, StRefill, StDone} state_e;

    state_e state_q, state_d;

    // Cache storage
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TagW-1:0]      tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] line_q [NUM_LINES];

    // Request captured at miss entry, so the transaction completes even if the CPU drops it
    logic [TagW-1:0]      miss_tag_q;
    logic [IdxW-1:0]      miss_idx_q;

    // Registered memory-side outputs
    logic                 mem_enable_q, mem_enable_d;
    logic                 mem_write_q, mem_write_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

    logic [TagW-1:0]      req_tag;
    logic [IdxW-1:0]      req_idx;
    logic [2:0]           req_word;
    logic                 unused_addr;

    logic                 hit;
    logic                 hit_idle;
    logic                 miss_start;
    logic                 store_hit;
    logic                 refill_done;
    logic [TagW-1:0]      lookup_tag;
    logic [IdxW-1:0]      lookup_idx;
    logic                 stall;
    logic [31:0]          load_data;

    assign req_tag     = bus.cpu_addr_i[31:10];
    assign req_idx     = bus.cpu_addr_i[9:5];
    assign req_word    = bus.cpu_addr_i[4:2];
    assign unused_addr = ^bus.cpu_addr_i[1:0];

    assign hit         = bus.cpu_req_i && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign hit_idle    = (state_q == StIdle) && hit && !rst_i;
    assign miss_start  = (state_q == StIdle) && bus.cpu_req_i && !hit && !rst_i;
    assign store_hit   = hit_idle && bus.cpu_we_i;
    assign refill_done = (state_q == StRefill) && bus.mem_ack_i && !rst_i;

    // In IDLE the live address selects the line; during a miss the captured one does
    assign lookup_idx  = (state_q == StIdle) ? req_idx : miss_idx_q;
    assign lookup_tag  = (state_q == StIdle) ? req_tag : miss_tag_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, stall and load-data decode
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        load_data = 32'd0;
        unique case (state_q)
            StIdle: begin
                if (bus.cpu_req_i) begin
                    if (hit) begin
                        if (!bus.cpu_we_i) begin
                            load_data = line_q[req_idx][{req_word, 5'b0} +: 32];
                        end
                    end else begin
                        stall   = 1'b1;
                        state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? StWriteback
                                                                         : StRefill;
                    end
                end
            end
            StWriteback: begin
                stall = 1'b1;
                if (bus.mem_ack_i) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                stall = 1'b1;
                if (bus.mem_ack_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                stall   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (rst_i) begin
            state_d   = StIdle;
            stall     = 1'b0;
            load_data = 32'd0;
        end
    end

    // Memory-side outputs are derived from the next state so they change only at clock edges
    always_comb begin
        mem_enable_d = (state_d == StWriteback) || (state_d == StRefill);
        mem_write_d  = (state_d == StWriteback);
        mem_addr_d   = 32'd0;
        mem_data_d   = '0;
        if (state_d == StWriteback) begin
            mem_addr_d = {tag_q[lookup_idx], lookup_idx, 5'b0};
            mem_data_d = line_q[lookup_idx];
        end else if (state_d == StRefill) begin
            mem_addr_d = {lookup_tag, lookup_idx, 5'b0};
        end
    end

    // Memory-side output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_data_q   <= '0;
        end else begin
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    // Capture the missing request's tag and index
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else if (miss_start) begin
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
        end
    end

    // Line metadata: valid, dirty and tag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (store_hit) begin
            dirty_q[req_idx] <= 1'b1;
        end else if (refill_done) begin
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
            tag_q[miss_idx_q]   <= miss_tag_q;
        end
    end

    // Line data: store-hit word merge or full-line refill; contents need no reset
    always_ff @(posedge clk_i) begin
        if (store_hit) begin
            line_q[req_idx][{req_word, 5'b0} +: 32] <= bus.cpu_data_i;
        end else if (refill_done) begin
            line_q[miss_idx_q] <= bus.mem_data_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Access statistics, wrapping naturally at 2^32
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            if (hit_idle) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

    assign bus.cpu_stall_o  = stall;
    assign bus.cpu_data_o   = load_data;
    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized accesses,
// checked against an array-based cache model and a sparse backing-memory model.
module tb_dcache_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_ctrl_if bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_line  [32];
    logic [255:0] backing [logic [26:0]];
    int unsigned  m_hits;
    int unsigned  m_misses;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] fetch_line(input logic [26:0] key);
        if (!backing.exists(key)) backing[key] = rand_line();
        return backing[key];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Starts at posedge+1; returns at posedge+1 with the request dropped.
    // d1/d2 choose writeback/refill ack latency in cycles (0 = random).
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int d1, input int d2);
        logic [4:0]   idx;
        logic [21:0]  tag;
        int           w;
        bit           hit, wb;
        int           n1, n2, stall_len, exp_len;
        logic [255:0] line;
        idx = addr[9:5];
        tag = addr[31:10];
        w   = int'(addr[4:2]);
        hit = m_valid[idx] && (m_tag[idx] == tag);
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = we;
        bus.cpu_addr_i = addr;
        bus.cpu_data_i = wdata;
        #1;
        if (!hit) begin
            m_misses++;
            wb        = m_valid[idx] && m_dirty[idx];
            stall_len = 0;
            n1        = 0;
            check("miss_stall", bus.cpu_stall_o, 1'b1);
            check("miss_no_mem", bus.mem_enable_o, 1'b0);
            stall_len += int'(bus.cpu_stall_o);
            @(posedge clk); #2;
            if (wb) begin
                n1 = (d1 != 0) ? d1 : int'($urandom_range(1, 4));
                for (int c = 0; c < n1; c++) begin
                    check("wb_en", bus.mem_enable_o, 1'b1);
                    check("wb_we", bus.mem_write_o, 1'b1);
                    check("wb_addr", bus.mem_addr_o, {m_tag[idx], idx, 5'b0});
                    check("wb_data", bus.mem_data_o, m_line[idx]);
                    stall_len += int'(bus.cpu_stall_o);
                    if (c == n1 - 1) bus.mem_ack_i = 1'b1;
                    @(posedge clk); #1;
                    bus.mem_ack_i = 1'b0;
                    #1;
                end
                backing[{m_tag[idx], idx}] = m_line[idx];
            end
            n2   = (d2 != 0) ? d2 : int'($urandom_range(1, 4));
            line = fetch_line({tag, idx});
            for (int c = 0; c < n2; c++) begin
                check("rf_en", bus.mem_enable_o, 1'b1);
                check("rf_we", bus.mem_write_o, 1'b0);
                check("rf_addr", bus.mem_addr_o, {tag, idx, 5'b0});
                stall_len += int'(bus.cpu_stall_o);
                if (c == n2 - 1) begin
                    bus.mem_data_i = line;
                    bus.mem_ack_i  = 1'b1;
                end
                @(posedge clk); #1;
                bus.mem_ack_i  = 1'b0;
                bus.mem_data_i = rand_line();
                #1;
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
            m_line[idx]  = line;
            check("done_stall", bus.cpu_stall_o, 1'b1);
            check("done_no_mem", bus.mem_enable_o, 1'b0);
            stall_len += int'(bus.cpu_stall_o);
            @(posedge clk); #2;
            exp_len = wb ? (n1 + n2 + 2) : (n2 + 2);
            check("stall_len", stall_len, exp_len);
        end
        m_hits++;
        check("hit_stall", bus.cpu_stall_o, 1'b0);
        check("hit_no_mem", bus.mem_enable_o, 1'b0);
        if (!we) begin
            check("load_data", bus.cpu_data_o, m_line[idx][w*32 +: 32]);
        end else begin
            m_line[idx][w*32 +: 32] = wdata;
            m_dirty[idx] = 1'b1;
        end
        @(posedge clk); #1;
        bus.cpu_req_i = 1'b0;
    endtask

    // One cycle with no request, optionally with a stray ack and garbage line data
    task automatic idle_cycle(input bit spurious);
        bus.cpu_req_i  = 1'b0;
        bus.mem_data_i = rand_line();
        bus.mem_ack_i  = spurious;
        #1;
        check("idle_stall", bus.cpu_stall_o, 1'b0);
        check("idle_data", bus.cpu_data_o, 32'd0);
        check("idle_no_mem", bus.mem_enable_o, 1'b0);
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
    endtask

    task automatic check_stats();
`ifdef DCACHE_STATS_EN
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] seed_line;
        logic [31:0]  addr;
        bus.cpu_req_i  = 1'b0;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'd0;
        bus.cpu_data_i = 32'd0;
        bus.mem_data_i = '0;
        bus.mem_ack_i  = 1'b0;
        model_reset();

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_stall", bus.cpu_stall_o, 1'b0);
        check("rst_data", bus.cpu_data_o, 32'd0);
        check("rst_en", bus.mem_enable_o, 1'b0);
        check("rst_we", bus.mem_write_o, 1'b0);
        check("rst_addr", bus.mem_addr_o, 32'd0);
        check("rst_mdata", bus.mem_data_o, 256'd0);
        check_stats();
        @(posedge clk); #1;

        // Clean miss with 3-cycle refill, then a hit on word 1
        seed_line = rand_line();
        seed_line[63:32] = 32'hDEAD_BEEF;
        backing[27'h20] = seed_line;
        access(1'b0, 32'h0000_0400, 32'd0, 0, 3);
        access(1'b0, 32'h0000_0404, 32'd0, 0, 0);

        // Store hit then load hit of the stored word
        access(1'b1, 32'h0000_0404, 32'h1234_5678, 0, 0);
        access(1'b0, 32'h0000_0404, 32'd0, 0, 0);

        // Dirty victim at index 0 forces writeback of 0x400 before refill of 0x800
        access(1'b0, 32'h0000_0800, 32'd0, 2, 2);

        // Stray acks with no request must not disturb the cache
        repeat (3) idle_cycle(1'b1);
        access(1'b0, 32'h0000_0800, 32'd0, 0, 0);
        check_stats();

        // Reset in the middle of a refill abandons the transaction
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_0400;
        #1;
        check("abort_miss_stall", bus.cpu_stall_o, 1'b1);
        @(posedge clk); #2;
        check("abort_rf_en", bus.mem_enable_o, 1'b1);
        check("abort_rf_addr", bus.mem_addr_o, 32'h0000_0400);
        rst = 1'b1;
        bus.cpu_req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        check("abort_en", bus.mem_enable_o, 1'b0);
        check("abort_we", bus.mem_write_o, 1'b0);
        check("abort_stall", bus.cpu_stall_o, 1'b0);
        check_stats();
        @(posedge clk); #1;

        // One miss and three hits (the refill hit included)
        access(1'b0, 32'h0000_0400, 32'd0, 0, 0);
        access(1'b0, 32'h0000_0404, 32'd0, 0, 0);
        access(1'b0, 32'h0000_0408, 32'd0, 0, 0);
        check_stats();

        // Randomized traffic over 4 tags x 4 indexes so lines keep colliding
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle_cycle(1'($urandom_range(0, 1)));
            end else begin
                addr = {22'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
                access(1'($urandom_range(0, 1)), addr, $urandom, 0, 0);
            end
        end
        check_stats();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
